// File: rtl/uart_tx_16550_pkg.sv
// Shared definitions for the 16550-style UART transmitter (and the matching
// receiver): FSM state encoding, word-length codes, parity-mode codes, the
// latched frame-format record and small helpers for word-length decoding.
package uart_tx_16550_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Indexed by {sticky_parity, eps}
  typedef enum logic [1:0] {
    PAR_ODD   = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_e;

  // Frame format captured from LCR at load time
  typedef struct packed {
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sticky_parity;
    logic       stb;
  } lcr_frame_t;

  // Index of the last data bit: 5..8 bits -> 4..7
  function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
    return {1'b1, wls};
  endfunction

  // Mask selecting the wls-defined data bits
  function automatic logic [7:0] wls_mask(input logic [1:0] wls);
    return 8'hFF >> (2'd3 - wls);
  endfunction

endpackage

// File: rtl/uart_tx_16550_if.sv
// TX FIFO read-side interface.
//   fifo_empty : FIFO empty flag (from FIFO)
//   fifo_dout  : first-word-fall-through head word, valid when !fifo_empty
//   pop        : 1-clk pop strobe (to FIFO)
// master = FIFO side, slave = transmitter side.
interface uart_tx_16550_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       pop;

  modport master (output fifo_empty, output fifo_dout, input pop);
  modport slave  (input fifo_empty, input fifo_dout, output pop);
endinterface

// File: rtl/uart_tx_16550_parity_gen.sv
// Combinational UART parity generator, shared by transmitter and receiver.
//   data_i          : data word; only the wls-selected low bits are covered
//   wls_i           : word length code (00=5 .. 11=8)
//   eps_i           : even parity select
//   sticky_parity_i : stick parity
//   parity_o        : parity bit to transmit / expect
module uart_parity_gen
  import uart_tx_16550_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic [1:0] wls_i,
  input  logic       eps_i,
  input  logic       sticky_parity_i,
  output logic       parity_o
);

  logic xr;

  always_comb begin
    xr = ^(data_i & wls_mask(wls_i));
    case (par_mode_e'({sticky_parity_i, eps_i}))
      PAR_ODD:   parity_o = ~xr;
      PAR_EVEN:  parity_o = xr;
      PAR_MARK:  parity_o = 1'b1;
      PAR_SPACE: parity_o = 1'b0;
      default:   parity_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_tx_16550.sv
// 16550-style UART transmitter. Pops bytes from the TX FIFO and serialises
// them LSB first as START, 5..8 DATA bits, optional PARITY and 1/1.5/2 STOP
// bits, each bit lasting OVERSAMPLE baud_pulse ticks.
//   clk, rst      : clock; asynchronous active-high reset
//   baud_pulse    : 1-clk strobe, OVERSAMPLE per bit time
//   fifo          : TX FIFO read side (fifo_empty, fifo_dout, pop)
//   wls/pen/eps/sticky_parity/stb : LCR frame format, latched at load
//   set_break     : forces tx low (registered, 1 clk latency)
//   tx            : serial output, idle high
//   tx_busy       : high while a frame is in progress
//   frame_done    : 1-clk strobe when the last stop period ends
module uart_tx_16550
  import uart_tx_16550_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_pulse,
  uart_tx_16550_if.slave    fifo,
  input  logic [1:0]        wls,
  input  logic              pen,
  input  logic              eps,
  input  logic              sticky_parity,
  input  logic              stb,
  input  logic              set_break,
  output logic              tx,
  output logic              tx_busy,
  output logic              frame_done
);

  // One extra bit over $clog2(OVERSAMPLE) so the same counter can time the
  // 1.5/2-bit stop period in a single pass.
  localparam int unsigned TW = $clog2(OVERSAMPLE) + 1;
  localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);

  uart_state_e   state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  lcr_frame_t    cfg_q, cfg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          brk_q;
  logic          pop_c;

  logic [TW-1:0] last_tick;
  logic          bit_end;
  logic          par_bit;

  uart_parity_gen u_par (
    .data_i          (data_q),
    .wls_i           (cfg_q.wls),
    .eps_i           (cfg_q.eps),
    .sticky_parity_i (cfg_q.sticky_parity),
    .parity_o        (par_bit)
  );

  always_comb begin
    last_tick = BIT_LAST;
    if (state_q == ST_STOP && cfg_q.stb) begin
      last_tick = (cfg_q.wls == WLS_5) ? STOP15_LAST : STOP2_LAST;
    end
    bit_end = baud_pulse && (tick_q == last_tick);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    cfg_d   = cfg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop_c   = 1'b0;

    // Ticks are never counted in IDLE, so a pulse on the load cycle is ignored
    if (state_q != ST_IDLE && baud_pulse) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo.fifo_empty) begin
          pop_c   = 1'b1;
          data_d  = fifo.fifo_dout;
          cfg_d.wls           = wls;
          cfg_d.pen           = pen;
          cfg_d.eps           = eps;
          cfg_d.sticky_parity = sticky_parity;
          cfg_d.stb           = stb;
          state_d = ST_START;
          tx_d    = 1'b0;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = data_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == last_bit_idx(cfg_q.wls)) begin
            if (cfg_q.pen) begin
              state_d = ST_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      cfg_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      cfg_q   <= cfg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      brk_q   <= set_break;
    end
  end

  // pop is combinational from the IDLE state; masked during reset so an
  // asynchronous reset never pops the FIFO.
  assign fifo.pop   = pop_c & ~rst;
  assign tx         = tx_q & ~brk_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_16550.sv
module tb_uart_tx_16550;
  typedef struct {
    logic [7:0] data;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sticky;
    logic       stb;
    logic       exp_par;
    int         stop_ticks;
  } vec_t;

  logic clk = 1'b0;
  logic rst, baud_pulse, pen, eps, sticky_parity, stb, set_break;
  logic [1:0] wls;
  logic tx, tx_busy, frame_done;

  uart_tx_16550_if bus ();

  logic [7:0] fmem [0:15];
  int wr = 0, rd = 0, pop_cnt = 0, done_cnt = 0;
  int errors = 0, checks = 0;

  assign bus.fifo_empty = (wr == rd);
  assign bus.fifo_dout  = fmem[rd[3:0]];

  uart_tx_16550 #(.OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .fifo          (bus.slave),
    .wls           (wls),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .stb           (stb),
    .set_break     (set_break),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.pop) begin
      checks++;
      if (wr == rd) begin
        errors++;
        $display("FAIL pop_when_empty: pop=1 required 0 (fifo empty)");
      end else begin
        rd++;
      end
      pop_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wr[3:0]] = d;
    wr++;
  endtask

  task automatic set_lcr(input vec_t v);
    wls = v.wls; pen = v.pen; eps = v.eps; sticky_parity = v.sticky; stb = v.stb;
  endtask

  // One idle clock then one clock with baud_pulse high; returns 1ns after
  // the counting edge.
  task automatic pulse();
    @(posedge clk); #1;
    baud_pulse = 1'b1;
    @(posedge clk); #1;
    baud_pulse = 1'b0;
    if (frame_done) done_cnt++;
  endtask

  task automatic wait_busy(output int gap);
    gap = 0;
    while (!tx_busy && gap < 20) begin
      @(posedge clk); #1;
      gap++;
    end
    chk("tx_busy_rise", tx_busy, 1);
  endtask

  // Runs one full frame; returns in the cycle where frame_done is high.
  task automatic run_frame(input vec_t v, input string tag, output int gap);
    logic [11:0] lv;
    int nlev, nbits, cnt, p0, d0;
    p0 = pop_cnt;
    d0 = done_cnt;
    set_lcr(v);
    wait_busy(gap);
    // scramble LCR: frame format must stay as latched
    wls = ~v.wls; pen = ~v.pen; eps = ~v.eps; sticky_parity = ~v.sticky; stb = ~v.stb;
    nbits = 5 + int'(v.wls);
    lv = '0;
    lv[0] = 1'b0;
    nlev = 1;
    for (int i = 0; i < nbits; i++) begin
      lv[nlev] = v.data[i];
      nlev++;
    end
    if (v.pen) begin
      lv[nlev] = v.exp_par;
      nlev++;
    end
    for (int b = 0; b < nlev; b++) begin
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
        if (tx === lv[b]) cnt++;
        pulse();
      end
      chk($sformatf("%s bit%0d level held (tx=%0d)", tag, b, lv[b]), cnt, 16);
    end
    cnt = 0;
    for (int k = 0; k < v.stop_ticks; k++) begin
      if (tx === 1'b1) cnt++;
      pulse();
    end
    chk($sformatf("%s stop ticks high", tag), cnt, v.stop_ticks);
    chk($sformatf("%s frame_done count", tag), done_cnt - d0, 1);
    chk($sformatf("%s frame_done at end", tag), frame_done, 1);
    chk($sformatf("%s tx_busy at end", tag), tx_busy, 0);
    chk($sformatf("%s tx idle", tag), tx, 1);
    chk($sformatf("%s pop count", tag), pop_cnt - p0, 1);
    set_lcr(v);
  endtask

  vec_t vecs [11];
  vec_t v;
  int gap, cnt, d0, p0;

  initial begin
    rst = 1'b1; baud_pulse = 1'b0; set_break = 1'b0;
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0; stb = 1'b0;

    //            data   wls    pen   eps   stk   stb   par  stop
    vecs[0]  = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16}; // 8N1
    vecs[1]  = '{8'h01, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16}; // 8O1
    vecs[2]  = '{8'h7F, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16}; // 7E1
    vecs[3]  = '{8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24}; // 5E1.5
    vecs[4]  = '{8'h00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16}; // mark
    vecs[5]  = '{8'hFF, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16}; // mark
    vecs[6]  = '{8'h00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16}; // space
    vecs[7]  = '{8'hFF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16}; // space
    vecs[8]  = '{8'hC3, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32}; // 6O2, upper bits ignored
    vecs[9]  = '{8'hE0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16}; // 5N1
    vecs[10] = '{8'h96, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32}; // 8E2

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset tx", tx, 1);
    chk("reset tx_busy", tx_busy, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset pop", bus.pop, 0);
    @(posedge clk); #1;
    chk("idle empty pop", bus.pop, 0);
    chk("idle empty busy", tx_busy, 0);

    // table-driven frames
    for (int i = 0; i < 11; i++) begin
      push(vecs[i].data);
      run_frame(vecs[i], $sformatf("vec%0d", i), gap);
      chk($sformatf("vec%0d load latency", i), gap, 1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d frame_done one clk", i), frame_done, 0);
    end

    // back-to-back 0x55, 0xAA
    v = vecs[0];
    v.data = 8'h55;
    push(8'h55);
    push(8'hAA);
    run_frame(v, "b2b0", gap);
    chk("b2b pop in done cycle", bus.pop, 1);
    v.data = 8'hAA;
    run_frame(v, "b2b1", gap);
    chk("b2b start gap", gap, 1);
    @(posedge clk); #1;

    // set_break for 40 pulses in DATA of 8N1 0xFF
    v = vecs[0];
    v.data = 8'hFF;
    set_lcr(v);
    d0 = done_cnt;
    push(8'hFF);
    wait_busy(gap);
    repeat (32) pulse();
    set_break = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (tx === 1'b0) cnt++;
      pulse();
    end
    chk("break tx low", cnt, 40);
    set_break = 1'b0;
    @(posedge clk); #1;
    chk("break release tx", tx, 1);
    cnt = 0;
    for (int k = 0; k < 88; k++) begin
      if (tx === 1'b1) cnt++;
      pulse();
    end
    chk("break rest high", cnt, 88);
    chk("break frame_done count", done_cnt - d0, 1);
    chk("break frame_done at 160", frame_done, 1);
    @(posedge clk); #1;

    // async reset at tick 5 of DATA bit 3
    v = vecs[0];
    v.data = 8'h00;
    set_lcr(v);
    push(8'h00);
    push(8'h3C);
    wait_busy(gap);
    repeat (69) pulse();
    chk("pre-reset tx", tx, 0);
    p0 = pop_cnt;
    rst = 1'b1;
    #1;
    chk("midreset tx", tx, 1);
    chk("midreset tx_busy", tx_busy, 0);
    chk("midreset pop", bus.pop, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset hold pop", bus.pop, 0);
    chk("reset no pops", pop_cnt - p0, 0);
    rst = 1'b0;
    v.data = 8'h3C;
    run_frame(v, "postreset", gap);
    chk("postreset load latency", gap, 1);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
